mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// MEM pipeline stage, directly downstream of exe_stage. Accepts EXE results, waits for the data-SRAM
// read response of loads, aligns/extends load data (lb/lbu/lh/lhu/lw/lwl/lwr), and forwards results to WB.
// Drives the MEM forward/block bus to decode and the ms_ex squash to EXE. Drops stale SRAM responses after a flush.
// PARAMETERS
// ES_TO_MS_BUS_WD  116  {ex,bd,eret,syscall,mfc0,mtc0,lb,lbu,lh,lhu,lw,lwl,lwr,res_from_mem,gr_we,dest[4:0],rt_value[31:0],exe_result[31:0],pc[31:0]}
// MS_TO_WS_BUS_WD   76  {ex,bd,eret,syscall,mfc0,mtc0,gr_we,dest[4:0],final_result[31:0],pc[31:0]}
// MS_FWD_BLK_BUS_WD 42  {fwd_valid[3:0],rf_dest[4:0],rf_data[31:0],blk_valid}
// PORTS
// clk               in   1    single clock; all state on posedge
// resetn            in   1    asynchronous, active-low reset
// ws_allowin        in   1    WB can accept
// ms_allowin        out  1    MEM can accept (to EXE)
// es_to_ms_valid    in   1    EXE presents valid bus
// es_to_ms_bus      in   116  EXE payload
// ms_to_ws_valid    out  1    MEM presents valid bus to WB
// ms_to_ws_bus      out  76   MEM payload
// data_sram_rdata   in   32   load read data
// data_sram_rvalid  in   1    one-cycle pulse, rdata valid
// ms_fwd_blk_bus    out  42   forward/block to decode
// ms_ex             out  1    valid MEM inst carries exception or eret (EXE suppresses stores/HI/LO)
// ms_inst_mfc0_o    out  1    valid MEM inst is mfc0 (decode blocks)
// ws_ex             in   1    WB exception flush
// eret_flush        in   1    WB eret flush
// BEHAVIOUR
// - Reset (async, resetn=0): ms_valid=0, state=IDLE, discard=0, rbuf_valid=0 => ms_allowin=1, ms_to_ws_valid=0,
//   ms_ex=0, ms_inst_mfc0_o=0, fwd_valid=0, blk_valid=0. Payload register not reset. Reset mid-wait drops everything.
// - Handshake: ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); on ms_allowin, ms_valid<=es_to_ms_valid;
//   payload captured when es_to_ms_valid & ms_allowin. ms_to_ws_valid = ms_valid & ms_ready_go & !flush,
//   flush = ws_ex | eret_flush; flush clears ms_valid next cycle.
// - Load request outstanding iff accepted inst has res_from_mem=1 and ex=0; exactly one rvalid per such inst,
//   arriving >=1 cycle after acceptance (earliest: the cycle ms_valid first reads 1).
// - FSM: IDLE (no load / not waiting) -> WAIT on accept of outstanding load. WAIT: rvalid & ws_allowin & !flush
//   -> IDLE (pass-through, 1-cycle MEM latency); rvalid & !ws_allowin -> HOLD, rdata into rbuf; flush -> IDLE
//   with discard<=1 unless rvalid same cycle. HOLD: ws_allowin -> IDLE; flush -> IDLE (no discard).
// - discard=1: next rvalid is swallowed and clears discard; a new load accepted meanwhile waits for the
//   following rvalid. rvalid with discard=0 outside WAIT: protocol error, ignored.
// - ms_ready_go = !outstanding | (WAIT & rvalid & !discard) | HOLD.
// - Load data ld=HOLD?rbuf:rdata, a=exe_result[1:0]: lb/lbu byte a, sign/zero ext; lh/lhu half a[1], sign/zero;
//   lw ld; lwl a=0..3: {ld[7:0],rt[23:0]},{ld[15:0],rt[15:0]},{ld[23:0],rt[7:0]},ld;
//   lwr a=0..3: ld,{rt[31:24],ld[31:8]},{rt[31:16],ld[31:16]},{rt[31:8],ld[31:24]}. Non-load: exe_result.
// - Forward: fwd_valid=4'hf when ms_valid & gr_we & ms_ready_go & !ex; rf_data=final_result.
//   blk_valid = ms_valid & res_from_mem & !ms_ready_go & !flush (decode stalls on match).
// - ms_ex = ms_valid & (ex | eret); ms_inst_mfc0_o = ms_valid & mfc0. Same-cycle flush + accept: accept is
//   blocked by EXE (es_to_ms_valid=0 under flush); flush wins over rvalid for output, rvalid still consumed.
// STRUCTURE
// - Bus widths as `ES_TO_MS_BUS_WD/`MS_TO_WS_BUS_WD/`MS_FWD_BLK_BUS_WD in mycpu.h; exe_stage bus grows by rt_value.
// - FSM state encoding (IDLE/WAIT/HOLD) as localparams in mycpu.h.
// - One sub-module: load_align (combinational ld/rt/addr/op -> final load value).
// TESTING
// - lw, rvalid 1 cycle after accept, rdata=32'h8badf00d, ws_allowin=1 -> ms_to_ws final_result=8badf00d, 1-cycle stage.
// - lb addr[1:0]=3, rdata=32'h80aabbcc -> ffffff80; lbu -> 00000080; lh addr=2 -> ffff80aa; lhu -> 000080aa.
// - lwl a=1, rt=11223344, rdata=aabbccdd -> ccdd3344; lwr a=2, same -> 1122aabb.
// - lw, rvalid while ws_allowin=0 for 3 cycles, rdata changes after -> HOLD keeps first rdata, blk_valid=0, fwd valid.
// - lw in WAIT, ws_ex pulse, then add accepted, then stale rvalid(111), then rvalid(222) for next lw -> 111 dropped, lw gets 222.
// - resetn low during WAIT -> all outputs at reset values same cycle; later stray rvalid ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: bus widths, bus layouts and the
// load-wait state machine encoding.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD   = 116;
   localparam int MS_TO_WS_BUS_WD   = 76;
   localparam int MS_FWD_BLK_BUS_WD = 42;

   // IDLE: nothing pending; WAIT: load issued, response not yet seen;
   // HOLD: response captured in the buffer while WB is stalled.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } ms_state_t;

   typedef struct packed {
      logic lb;
      logic lbu;
      logic lh;
      logic lhu;
      logic lw;
      logic lwl;
      logic lwr;
   } ld_op_t;

   typedef struct packed {
      logic        ex;
      logic        bd;
      logic        eret;
      logic        syscall;
      logic        mfc0;
      logic        mtc0;
      ld_op_t      op;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] rt_value;
      logic [31:0] exe_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        ex;
      logic        bd;
      logic        eret;
      logic        syscall;
      logic        mfc0;
      logic        mtc0;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   typedef struct packed {
      logic [3:0]  fwd_valid;
      logic [4:0]  rf_dest;
      logic [31:0] rf_data;
      logic        blk_valid;
   } ms_fwd_blk_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Turns a raw 32-bit SRAM word into the architectural load result, handling
// byte/half extraction with sign or zero extension and the unaligned lwl/lwr
// merges with the old rt value. Non-loads pass the EXE result through.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic        i_isLoad,
   input  ld_op_t      i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_ld,
   input  logic [31:0] i_rt,
   input  logic [31:0] i_exeResult,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_lwl;
   logic [31:0] w_lwr;

   // Select the addressed byte lane and build the lwl/lwr merged words.
   always_comb begin
      w_byte = i_ld[7:0];
      w_lwl  = i_ld;
      w_lwr  = i_ld;
      case (i_addr)
         2'd0: begin
            w_byte = i_ld[7:0];
            w_lwl  = {i_ld[7:0], i_rt[23:0]};
            w_lwr  = i_ld;
         end
         2'd1: begin
            w_byte = i_ld[15:8];
            w_lwl  = {i_ld[15:0], i_rt[15:0]};
            w_lwr  = {i_rt[31:24], i_ld[31:8]};
         end
         2'd2: begin
            w_byte = i_ld[23:16];
            w_lwl  = {i_ld[23:0], i_rt[7:0]};
            w_lwr  = {i_rt[31:16], i_ld[31:16]};
         end
         default: begin
            w_byte = i_ld[31:24];
            w_lwl  = i_ld;
            w_lwr  = {i_rt[31:8], i_ld[31:24]};
         end
      endcase
   end

   assign w_half = i_addr[1] ? i_ld[31:16] : i_ld[15:0];

   // Pick the final value by load flavour; a full word is the fallback.
   always_comb begin
      o_result = i_exeResult;
      if (i_isLoad) begin
         if (i_op.lb)       o_result = {{24{w_byte[7]}}, w_byte};
         else if (i_op.lbu) o_result = {24'd0, w_byte};
         else if (i_op.lh)  o_result = {{16{w_half[15]}}, w_half};
         else if (i_op.lhu) o_result = {16'd0, w_half};
         else if (i_op.lwl) o_result = w_lwl;
         else if (i_op.lwr) o_result = w_lwr;
         else if (i_op.lw)  o_result = i_ld;
         else               o_result = i_ld;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for the data-SRAM
// response of loads, buffers it while WB stalls, drops responses belonging to
// flushed loads, and drives the forward/block bus back to decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         ws_allowin,
   output logic                         ms_allowin,
   input  logic                         es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
   output logic                         ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
   input  logic [31:0]                  data_sram_rdata,
   input  logic                         data_sram_rvalid,
   output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus,
   output logic                         ms_ex,
   output logic                         ms_inst_mfc0_o,
   input  logic                         ws_ex,
   input  logic                         eret_flush
);

   es_to_ms_t   w_esBus;
   es_to_ms_t   r_payload;
   ms_state_t   r_state;
   ms_state_t   w_stateNext;
   logic        r_msValid;
   logic        r_discard;
   logic        w_discardNext;
   logic [31:0] r_rbuf;
   logic        w_rbufLoad;
   logic        w_flush;
   logic        w_outstanding;
   logic        w_rvalidLive;
   logic        w_readyGo;
   logic        w_accept;
   logic        w_acceptLoad;
   logic [31:0] w_ld;
   logic [31:0] w_finalResult;
   ms_to_ws_t   w_wsBus;
   ms_fwd_blk_t w_fwdBus;

   assign w_esBus       = es_to_ms_bus;
   assign w_flush       = ws_ex | eret_flush;
   assign w_outstanding = r_payload.res_from_mem & ~r_payload.ex;
   assign w_rvalidLive  = data_sram_rvalid & ~r_discard;
   assign w_readyGo     = ~w_outstanding
                        | ((r_state == ST_WAIT) & w_rvalidLive)
                        | (r_state == ST_HOLD);
   assign ms_allowin    = ~r_msValid | (w_readyGo & ws_allowin);
   assign w_accept      = es_to_ms_valid & ms_allowin & ~w_flush;
   assign w_acceptLoad  = w_accept & w_esBus.res_from_mem & ~w_esBus.ex;

   // Stage occupancy: a flush empties the stage, otherwise refill on allowin.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)         r_msValid <= 1'b0;
      else if (w_flush)    r_msValid <= 1'b0;
      else if (ms_allowin) r_msValid <= es_to_ms_valid;
   end

   // Instruction payload needs no reset; it is qualified by r_msValid.
   always_ff @(posedge clk) begin
      if (w_accept) r_payload <= w_esBus;
   end

   // Next-state for the load wait machine, the stale-response flag and the
   // response buffer. A single flag tracks one stale response; a flushed load
   // that is itself behind a stale response keeps the flag set.
   always_comb begin
      w_stateNext   = r_state;
      w_discardNext = r_discard;
      w_rbufLoad    = 1'b0;
      if (data_sram_rvalid & r_discard) w_discardNext = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (w_flush) begin
               w_stateNext = ST_IDLE;
               if (!data_sram_rvalid || r_discard) w_discardNext = 1'b1;
            end else if (w_rvalidLive) begin
               if (ws_allowin) begin
                  w_stateNext = ST_IDLE;
               end else begin
                  w_stateNext = ST_HOLD;
                  w_rbufLoad  = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (w_flush || ws_allowin) w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
      if (w_acceptLoad) w_stateNext = ST_WAIT;
   end

   // State, stale-response flag and response buffer registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_discard <= 1'b0;
         r_rbuf    <= 32'd0;
      end else begin
         r_state   <= w_stateNext;
         r_discard <= w_discardNext;
         if (w_rbufLoad) r_rbuf <= data_sram_rdata;
      end
   end

   assign w_ld = (r_state == ST_HOLD) ? r_rbuf : data_sram_rdata;

   mem_stage_load_align u_align (
      .i_isLoad    (r_payload.res_from_mem),
      .i_op        (r_payload.op),
      .i_addr      (r_payload.exe_result[1:0]),
      .i_ld        (w_ld),
      .i_rt        (r_payload.rt_value),
      .i_exeResult (r_payload.exe_result),
      .o_result    (w_finalResult)
   );

   assign ms_to_ws_valid       = r_msValid & w_readyGo & ~w_flush;
   assign w_wsBus.ex           = r_payload.ex;
   assign w_wsBus.bd           = r_payload.bd;
   assign w_wsBus.eret         = r_payload.eret;
   assign w_wsBus.syscall      = r_payload.syscall;
   assign w_wsBus.mfc0         = r_payload.mfc0;
   assign w_wsBus.mtc0         = r_payload.mtc0;
   assign w_wsBus.gr_we        = r_payload.gr_we;
   assign w_wsBus.dest         = r_payload.dest;
   assign w_wsBus.final_result = w_finalResult;
   assign w_wsBus.pc           = r_payload.pc;
   assign ms_to_ws_bus         = w_wsBus;

   assign w_fwdBus.fwd_valid = {4{r_msValid & r_payload.gr_we & w_readyGo & ~r_payload.ex}};
   assign w_fwdBus.rf_dest   = r_payload.dest;
   assign w_fwdBus.rf_data   = w_finalResult;
   assign w_fwdBus.blk_valid = r_msValid & r_payload.res_from_mem & ~w_readyGo & ~w_flush;
   assign ms_fwd_blk_bus     = w_fwdBus;

   assign ms_ex          = r_msValid & (r_payload.ex | r_payload.eret);
   assign ms_inst_mfc0_o = r_msValid & r_payload.mfc0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load alignment, WB stall buffering,
// stale response dropping after a flush, reset mid-wait and back-to-back flow.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam ld_op_t OP_NONE = 7'b0000000;
   localparam ld_op_t OP_LB   = 7'b1000000;
   localparam ld_op_t OP_LBU  = 7'b0100000;
   localparam ld_op_t OP_LH   = 7'b0010000;
   localparam ld_op_t OP_LHU  = 7'b0001000;
   localparam ld_op_t OP_LW   = 7'b0000100;
   localparam ld_op_t OP_LWL  = 7'b0000010;
   localparam ld_op_t OP_LWR  = 7'b0000001;

   logic        clk;
   logic        resetn;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   es_to_ms_t   esBus;
   logic        ms_to_ws_valid;
   ms_to_ws_t   wsBus;
   logic [31:0] data_sram_rdata;
   logic        data_sram_rvalid;
   ms_fwd_blk_t fwdBus;
   logic        ms_ex;
   logic        ms_inst_mfc0_o;
   logic        ws_ex;
   logic        eret_flush;

   int compared   = 0;
   int mismatched = 0;

   ld_op_t      alignOp    [13] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR, OP_LB,
                                    OP_LBU, OP_LH, OP_LWL, OP_LWR, OP_LWL, OP_LWR};
   logic [1:0]  alignAddr  [13] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0,
                                    2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
   logic [31:0] alignRdata [13] = '{32'h80aabbcc, 32'h80aabbcc, 32'h80aabbcc, 32'h80aabbcc,
                                    32'haabbccdd, 32'haabbccdd, 32'h80aabbcc, 32'h80aabbcc,
                                    32'h80aabbcc, 32'haabbccdd, 32'haabbccdd, 32'haabbccdd,
                                    32'haabbccdd};
   logic [31:0] alignExp   [13] = '{32'hffffff80, 32'h00000080, 32'hffff80aa, 32'h000080aa,
                                    32'hccdd3344, 32'h1122aabb, 32'hffffffcc, 32'h000000bb,
                                    32'hffffbbcc, 32'hdd223344, 32'h112233aa, 32'haabbccdd,
                                    32'h11aabbcc};

   mem_stage dut (
      .clk              (clk),
      .resetn           (resetn),
      .ws_allowin       (ws_allowin),
      .ms_allowin       (ms_allowin),
      .es_to_ms_valid   (es_to_ms_valid),
      .es_to_ms_bus     (esBus),
      .ms_to_ws_valid   (ms_to_ws_valid),
      .ms_to_ws_bus     (wsBus),
      .data_sram_rdata  (data_sram_rdata),
      .data_sram_rvalid (data_sram_rvalid),
      .ms_fwd_blk_bus   (fwdBus),
      .ms_ex            (ms_ex),
      .ms_inst_mfc0_o   (ms_inst_mfc0_o),
      .ws_ex            (ws_ex),
      .eret_flush       (eret_flush)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic es_to_ms_t mkInst(input logic isLoad, input ld_op_t op,
                                        input logic [31:0] rt, input logic [31:0] res,
                                        input logic [4:0] dest);
      es_to_ms_t t;
      t              = '0;
      t.res_from_mem = isLoad;
      t.op           = op;
      t.gr_we        = 1'b1;
      t.dest         = dest;
      t.rt_value     = rt;
      t.exe_result   = res;
      t.pc           = 32'hbfc00000 + {25'd0, dest, 2'b00};
      return t;
   endfunction

   task automatic stepClk;
      @(posedge clk);
      #1;
   endtask

   task automatic acceptInst(input es_to_ms_t inst);
      es_to_ms_valid = 1'b1;
      esBus          = inst;
      stepClk();
      es_to_ms_valid = 1'b0;
      esBus          = '0;
   endtask

   task automatic test_reset;
      resetn           = 1'b0;
      ws_allowin       = 1'b1;
      es_to_ms_valid   = 1'b0;
      esBus            = '0;
      data_sram_rdata  = 32'd0;
      data_sram_rvalid = 1'b0;
      ws_ex            = 1'b0;
      eret_flush       = 1'b0;
      #2;
      compared++;
      if ({ms_allowin, ms_to_ws_valid, ms_ex, ms_inst_mfc0_o, fwdBus.fwd_valid, fwdBus.blk_valid} !== 9'b1_0_0_0_0000_0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got %b expected %b",
                  {ms_allowin, ms_to_ws_valid, ms_ex, ms_inst_mfc0_o, fwdBus.fwd_valid, fwdBus.blk_valid}, 9'b100000000);
      end
      stepClk();
      stepClk();
      resetn = 1'b1;
      stepClk();
   endtask

   task automatic test_lw;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00001000, 5'd5));
      #1;
      compared++;
      if ({fwdBus.blk_valid, ms_to_ws_valid, ms_allowin} !== 3'b100) begin
         mismatched++;
         $display("[TB] FAIL lw_wait: got blk/valid/allowin %b expected 100",
                  {fwdBus.blk_valid, ms_to_ws_valid, ms_allowin});
      end
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h8badf00d;
      #1;
      compared++;
      if ({ms_to_ws_valid, wsBus.final_result, wsBus.dest, wsBus.pc, fwdBus.fwd_valid, fwdBus.rf_data}
          !== {1'b1, 32'h8badf00d, 5'd5, 32'hbfc00014, 4'hf, 32'h8badf00d}) begin
         mismatched++;
         $display("[TB] FAIL lw_result: got valid %b res %h dest %0d pc %h fwd %h data %h expected 1 8badf00d 5 bfc00014 f 8badf00d",
                  ms_to_ws_valid, wsBus.final_result, wsBus.dest, wsBus.pc, fwdBus.fwd_valid, fwdBus.rf_data);
      end
      stepClk();
      data_sram_rvalid = 1'b0;
      data_sram_rdata  = 32'd0;
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL lw_drain: got valid/allowin %b expected 01", {ms_to_ws_valid, ms_allowin});
      end
   endtask

   task automatic test_align;
      for (int i = 0; i < 13; i++) begin
         acceptInst(mkInst(1'b1, alignOp[i], 32'h11223344, {30'h00000400, alignAddr[i]}, 5'd6));
         #1;
         data_sram_rvalid = 1'b1;
         data_sram_rdata  = alignRdata[i];
         #1;
         compared++;
         if ({ms_to_ws_valid, wsBus.final_result} !== {1'b1, alignExp[i]}) begin
            mismatched++;
            $display("[TB] FAIL align_%0d: got valid %b res %h expected 1 %h",
                     i, ms_to_ws_valid, wsBus.final_result, alignExp[i]);
         end
         stepClk();
         data_sram_rvalid = 1'b0;
      end
   endtask

   task automatic test_hold;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00002000, 5'd7));
      #1;
      ws_allowin       = 1'b0;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h11111111;
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_allowin, fwdBus.blk_valid} !== 3'b100) begin
         mismatched++;
         $display("[TB] FAIL hold_enter: got valid/allowin/blk %b expected 100",
                  {ms_to_ws_valid, ms_allowin, fwdBus.blk_valid});
      end
      stepClk();
      data_sram_rvalid = 1'b0;
      data_sram_rdata  = 32'hdeadbeef;
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++;
         if ({wsBus.final_result, ms_to_ws_valid, fwdBus.blk_valid, fwdBus.fwd_valid, ms_allowin}
             !== {32'h11111111, 1'b1, 1'b0, 4'hf, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL hold_cycle_%0d: got res %h valid %b blk %b fwd %h allowin %b expected 11111111 1 0 f 0",
                     i, wsBus.final_result, ms_to_ws_valid, fwdBus.blk_valid, fwdBus.fwd_valid, ms_allowin);
         end
         stepClk();
      end
      ws_allowin = 1'b1;
      #1;
      compared++;
      if ({wsBus.final_result, ms_allowin} !== {32'h11111111, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL hold_release: got res %h allowin %b expected 11111111 1",
                  wsBus.final_result, ms_allowin);
      end
      stepClk();
      #1;
      compared++;
      if (ms_to_ws_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL hold_drain: got valid %b expected 0", ms_to_ws_valid);
      end
   endtask

   task automatic test_flush_discard;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00003000, 5'd3));
      #1;
      ws_ex = 1'b1;
      #1;
      compared++;
      if ({ms_to_ws_valid, fwdBus.blk_valid} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL flush_mask: got valid/blk %b expected 00", {ms_to_ws_valid, fwdBus.blk_valid});
      end
      stepClk();
      ws_ex = 1'b0;
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL flush_empty: got valid/allowin %b expected 01", {ms_to_ws_valid, ms_allowin});
      end
      acceptInst(mkInst(1'b0, OP_NONE, 32'd0, 32'h00000055, 5'd4));
      #1;
      compared++;
      if ({ms_to_ws_valid, wsBus.final_result} !== {1'b1, 32'h00000055}) begin
         mismatched++;
         $display("[TB] FAIL flush_add: got valid %b res %h expected 1 00000055",
                  ms_to_ws_valid, wsBus.final_result);
      end
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00003004, 5'd8));
      #1;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h00000111;
      #1;
      compared++;
      if ({ms_to_ws_valid, fwdBus.blk_valid} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL stale_drop: got valid/blk %b expected 01", {ms_to_ws_valid, fwdBus.blk_valid});
      end
      stepClk();
      data_sram_rvalid = 1'b0;
      #1;
      compared++;
      if ({ms_to_ws_valid, fwdBus.blk_valid} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL stale_still_wait: got valid/blk %b expected 01", {ms_to_ws_valid, fwdBus.blk_valid});
      end
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h00000222;
      #1;
      compared++;
      if ({ms_to_ws_valid, wsBus.final_result} !== {1'b1, 32'h00000222}) begin
         mismatched++;
         $display("[TB] FAIL fresh_data: got valid %b res %h expected 1 00000222",
                  ms_to_ws_valid, wsBus.final_result);
      end
      stepClk();
      data_sram_rvalid = 1'b0;
   endtask

   task automatic test_exception;
      es_to_ms_t t;
      t    = mkInst(1'b1, OP_LW, 32'd0, 32'h00004001, 5'd9);
      t.ex = 1'b1;
      acceptInst(t);
      #1;
      compared++;
      if ({ms_ex, ms_to_ws_valid, fwdBus.blk_valid, fwdBus.fwd_valid, wsBus.ex} !== 8'b1_1_0_0000_1) begin
         mismatched++;
         $display("[TB] FAIL exc_load: got ex/valid/blk/fwd/busex %b expected 11000001",
                  {ms_ex, ms_to_ws_valid, fwdBus.blk_valid, fwdBus.fwd_valid, wsBus.ex});
      end
      t      = mkInst(1'b0, OP_NONE, 32'd0, 32'h00000abc, 5'd10);
      t.mfc0 = 1'b1;
      acceptInst(t);
      #1;
      compared++;
      if ({ms_inst_mfc0_o, ms_ex, ms_to_ws_valid} !== 3'b101) begin
         mismatched++;
         $display("[TB] FAIL mfc0_flag: got mfc0/ex/valid %b expected 101", {ms_inst_mfc0_o, ms_ex, ms_to_ws_valid});
      end
      eret_flush = 1'b1;
      #1;
      compared++;
      if (ms_to_ws_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL eret_mask: got valid %b expected 0", ms_to_ws_valid);
      end
      stepClk();
      eret_flush = 1'b0;
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_inst_mfc0_o} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL eret_clear: got valid/mfc0 %b expected 00", {ms_to_ws_valid, ms_inst_mfc0_o});
      end
      t      = mkInst(1'b0, OP_NONE, 32'd0, 32'h0, 5'd0);
      t.eret = 1'b1;
      acceptInst(t);
      #1;
      compared++;
      if (ms_ex !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL eret_ex: got ms_ex %b expected 1", ms_ex);
      end
      stepClk();
   endtask

   task automatic test_reset_mid_wait;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00005000, 5'd11));
      #1;
      resetn = 1'b0;
      #1;
      compared++;
      if ({ms_allowin, ms_to_ws_valid, ms_ex, ms_inst_mfc0_o, fwdBus.fwd_valid, fwdBus.blk_valid} !== 9'b1_0_0_0_0000_0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_wait: got %b expected %b",
                  {ms_allowin, ms_to_ws_valid, ms_ex, ms_inst_mfc0_o, fwdBus.fwd_valid, fwdBus.blk_valid}, 9'b100000000);
      end
      stepClk();
      resetn = 1'b1;
      #1;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h99999999;
      #1;
      compared++;
      if ({ms_to_ws_valid, fwdBus.blk_valid, ms_allowin} !== 3'b001) begin
         mismatched++;
         $display("[TB] FAIL stray_rvalid: got valid/blk/allowin %b expected 001",
                  {ms_to_ws_valid, fwdBus.blk_valid, ms_allowin});
      end
      stepClk();
      data_sram_rvalid = 1'b0;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00005004, 5'd12));
      #1;
      compared++;
      if ({fwdBus.blk_valid, ms_to_ws_valid} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL post_reset_wait: got blk/valid %b expected 10", {fwdBus.blk_valid, ms_to_ws_valid});
      end
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h0abc0abc;
      #1;
      compared++;
      if ({ms_to_ws_valid, wsBus.final_result} !== {1'b1, 32'h0abc0abc}) begin
         mismatched++;
         $display("[TB] FAIL post_reset_load: got valid %b res %h expected 1 0abc0abc",
                  ms_to_ws_valid, wsBus.final_result);
      end
      stepClk();
      data_sram_rvalid = 1'b0;
   endtask

   task automatic test_back_to_back;
      acceptInst(mkInst(1'b1, OP_LW, 32'd0, 32'h00006000, 5'd13));
      #1;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h13579bdf;
      es_to_ms_valid   = 1'b1;
      esBus            = mkInst(1'b0, OP_NONE, 32'd0, 32'h00000077, 5'd14);
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_allowin, wsBus.final_result} !== {1'b1, 1'b1, 32'h13579bdf}) begin
         mismatched++;
         $display("[TB] FAIL b2b_load: got valid %b allowin %b res %h expected 1 1 13579bdf",
                  ms_to_ws_valid, ms_allowin, wsBus.final_result);
      end
      stepClk();
      data_sram_rvalid = 1'b0;
      esBus            = mkInst(1'b1, OP_LW, 32'd0, 32'h00006004, 5'd15);
      #1;
      compared++;
      if ({ms_to_ws_valid, ms_allowin, wsBus.final_result} !== {1'b1, 1'b1, 32'h00000077}) begin
         mismatched++;
         $display("[TB] FAIL b2b_add: got valid %b allowin %b res %h expected 1 1 00000077",
                  ms_to_ws_valid, ms_allowin, wsBus.final_result);
      end
      stepClk();
      es_to_ms_valid = 1'b0;
      esBus          = '0;
      #1;
      compared++;
      if ({fwdBus.blk_valid, ms_to_ws_valid, fwdBus.rf_dest} !== {1'b1, 1'b0, 5'd15}) begin
         mismatched++;
         $display("[TB] FAIL b2b_wait: got blk %b valid %b dest %0d expected 1 0 15",
                  fwdBus.blk_valid, ms_to_ws_valid, fwdBus.rf_dest);
      end
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = 32'h2468ace0;
      #1;
      compared++;
      if ({ms_to_ws_valid, wsBus.final_result} !== {1'b1, 32'h2468ace0}) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: got valid %b res %h expected 1 2468ace0",
                  ms_to_ws_valid, wsBus.final_result);
      end
      stepClk();
      data_sram_rvalid = 1'b0;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_lw();
      test_align();
      test_hold();
      test_flush_discard();
      test_exception();
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
